// File: rtl/riscv_disassembler.sv
// Streaming RV32I disassembler: one accepted instruction word becomes a line of
// ASCII assembly text, emitted one registered character per handshake.
module riscv_disassembler (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] inst_in,
  input  logic        inst_valid_in,
  output logic        inst_ready_out,
  output logic [7:0]  char_out,
  output logic        char_valid_out,
  input  logic        char_ready_in,
  output logic        char_last_out,
  output logic        error_out
);

  typedef enum logic [1:0] {S_IDLE, S_MNEM, S_OPS, S_NL} state_e;
  typedef enum logic [2:0] {F_R, F_I, F_LD, F_ST, F_BR, F_J, F_ERR} fmt_e;
  typedef enum logic [2:0] {T_RD, T_RS1, T_RS2, T_IMM, T_COMMA, T_LP, T_RP, T_END} tok_e;

  typedef struct packed {
    logic        illegal;
    logic [39:0] mnem;  // space padded, first character in the top byte
    logic [2:0]  mlen;
    fmt_e        fmt;
    logic [31:0] imm;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] w);
    dec_t       d;
    logic       ok;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    ok = 1'b1;
    d.illegal = 1'b0;
    d.mnem = "???  ";
    d.mlen = 3'd3;
    d.fmt = F_ERR;
    d.imm = {{20{w[31]}}, w[31:20]};
    case (w[6:0])
      7'b0110011: begin
        d.fmt = F_R;
        ok = (f7 == 7'b0000000) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
        case (f3)
          3'b000:  d.mnem = f7[5] ? "sub  " : "add  ";
          3'b001:  d.mnem = "sll  ";
          3'b010:  d.mnem = "slt  ";
          3'b011:  d.mnem = "sltu ";
          3'b100:  d.mnem = "xor  ";
          3'b101:  d.mnem = f7[5] ? "sra  " : "srl  ";
          3'b110:  d.mnem = "or   ";
          default: d.mnem = "and  ";
        endcase
      end
      7'b0010011: begin
        d.fmt = F_I;
        case (f3)
          3'b000: d.mnem = "addi ";
          3'b001: begin
            d.mnem = "slli ";
            d.imm = {27'd0, w[24:20]};
            ok = (f7 == 7'b0000000);
          end
          3'b010: d.mnem = "slti ";
          3'b011: d.mnem = "sltiu";
          3'b100: d.mnem = "xori ";
          3'b101: begin
            d.mnem = f7[5] ? "srai " : "srli ";
            d.imm = {27'd0, w[24:20]};
            ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          end
          3'b110:  d.mnem = "ori  ";
          default: d.mnem = "andi ";
        endcase
      end
      7'b0000011: begin
        d.fmt = F_LD;
        case (f3)
          3'b000:  d.mnem = "lb   ";
          3'b001:  d.mnem = "lh   ";
          3'b010:  d.mnem = "lw   ";
          3'b100:  d.mnem = "lbu  ";
          3'b101:  d.mnem = "lhu  ";
          default: ok = 1'b0;
        endcase
      end
      7'b0100011: begin
        d.fmt = F_ST;
        d.imm = {{20{w[31]}}, w[31:25], w[11:7]};
        case (f3)
          3'b000:  d.mnem = "sb   ";
          3'b001:  d.mnem = "sh   ";
          3'b010:  d.mnem = "sw   ";
          default: ok = 1'b0;
        endcase
      end
      7'b1100011: begin
        d.fmt = F_BR;
        d.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        case (f3)
          3'b000:  d.mnem = "beq  ";
          3'b001:  d.mnem = "bne  ";
          3'b100:  d.mnem = "blt  ";
          3'b101:  d.mnem = "bge  ";
          3'b110:  d.mnem = "bltu ";
          3'b111:  d.mnem = "bgeu ";
          default: ok = 1'b0;
        endcase
      end
      7'b1101111: begin
        d.fmt = F_J;
        d.mnem = "jal  ";
        d.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      end
      7'b1100111: begin
        d.fmt = F_LD;
        d.mnem = "jalr ";
        ok = (f3 == 3'b000);
      end
      7'b0110111: begin
        d.fmt = F_J;
        d.mnem = "lui  ";
        d.imm = {w[31:12], 12'h000};
      end
      7'b0010111: begin
        d.fmt = F_J;
        d.mnem = "auipc";
        d.imm = {w[31:12], 12'h000};
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      d.illegal = 1'b1;
      d.mnem = "???  ";
      d.fmt = F_ERR;
      d.imm = w;
    end
    d.mlen = (d.mnem[31:24] == 8'h20) ? 3'd1 :
             (d.mnem[23:16] == 8'h20) ? 3'd2 :
             (d.mnem[15:8]  == 8'h20) ? 3'd3 :
             (d.mnem[7:0]   == 8'h20) ? 3'd4 : 3'd5;
    return d;
  endfunction

  // Operand text is a fixed token sequence per format; entry 0 is emitted first.
  function automatic tok_e tok_at(input fmt_e f, input logic [2:0] i);
    logic [7:0][2:0] seq;
    seq = {8{T_END}};
    case (f)
      F_R:     seq[4:0] = {T_RS2, T_COMMA, T_RS1, T_COMMA, T_RD};
      F_I:     seq[4:0] = {T_IMM, T_COMMA, T_RS1, T_COMMA, T_RD};
      F_LD:    seq[5:0] = {T_RP, T_RS1, T_LP, T_IMM, T_COMMA, T_RD};
      F_ST:    seq[5:0] = {T_RP, T_RS1, T_LP, T_IMM, T_COMMA, T_RS2};
      F_BR:    seq[4:0] = {T_IMM, T_COMMA, T_RS2, T_COMMA, T_RS1};
      F_J:     seq[2:0] = {T_IMM, T_COMMA, T_RD};
      default: seq[0] = T_IMM;
    endcase
    return tok_e'(seq[i]);
  endfunction

  // regs = {rs2, rs1, rd}
  function automatic logic [4:0] sel_reg(input tok_e k, input logic [14:0] regs);
    case (k)
      T_RS1:   return regs[9:5];
      T_RS2:   return regs[14:10];
      default: return regs[4:0];
    endcase
  endfunction

  function automatic logic [3:0] tok_len(input tok_e k, input logic [4:0] r);
    case (k)
      T_RD, T_RS1, T_RS2: return (r >= 5'd10) ? 4'd3 : 4'd2;
      T_IMM:              return 4'd10;
      default:            return 4'd1;
    endcase
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'd0, n} : 8'h37 + {4'd0, n};
  endfunction

  function automatic logic [7:0] tok_char(input tok_e k, input logic [3:0] sub,
                                          input logic [4:0] r, input logic [31:0] imm);
    logic [1:0] tens;
    logic [4:0] ones;
    logic [2:0] ni;
    tens = (r >= 5'd30) ? 2'd3 : (r >= 5'd20) ? 2'd2 : (r >= 5'd10) ? 2'd1 : 2'd0;
    ones = r - {3'd0, tens} * 5'd10;
    ni = 3'(4'd9 - sub);
    case (k)
      T_RD, T_RS1, T_RS2: begin
        if (sub == 4'd0) return "x";
        if (tens != 2'd0 && sub == 4'd1) return 8'h30 + {6'd0, tens};
        return 8'h30 + {3'd0, ones};
      end
      T_IMM: begin
        if (sub == 4'd0) return "0";
        if (sub == 4'd1) return "x";
        return hex_char(imm[{ni, 2'b00} +: 4]);
      end
      T_COMMA: return ",";
      T_LP:    return "(";
      T_RP:    return ")";
      default: return 8'h00;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  tok_q, tok_d;
  logic [3:0]  sub_q, sub_d;
  logic [31:0] inst_q, inst_d;
  fmt_e        fmt_q, fmt_d;
  logic [2:0]  mlen_q, mlen_d;
  logic        err_q, err_d;
  logic [7:0]  char_q, char_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;

  logic        accept;
  tok_e        cur_tok, nxt_tok, d_tok;
  logic [3:0]  cur_len;
  dec_t        dec_d;

  assign accept = (state_q == S_IDLE) && inst_valid_in;

  always_comb begin
    state_d = state_q;
    tok_d   = tok_q;
    sub_d   = sub_q;
    inst_d  = inst_q;
    cur_tok = tok_at(fmt_q, tok_q);
    nxt_tok = tok_at(fmt_q, tok_q + 3'd1);
    cur_len = tok_len(cur_tok, sel_reg(cur_tok, {inst_q[24:20], inst_q[19:15], inst_q[11:7]}));
    case (state_q)
      S_IDLE: if (inst_valid_in) begin
        inst_d  = inst_in;
        state_d = S_MNEM;
        tok_d   = 3'd0;
        sub_d   = 4'd0;
      end
      S_MNEM: if (char_ready_in) begin
        // the character at index mlen is the separating space
        if (sub_q == {1'b0, mlen_q}) begin
          state_d = S_OPS;
          tok_d   = 3'd0;
          sub_d   = 4'd0;
        end else begin
          sub_d = sub_q + 4'd1;
        end
      end
      S_OPS: if (char_ready_in) begin
        if (sub_q == cur_len - 4'd1) begin
          if (nxt_tok == T_END) begin
            state_d = S_NL;
          end else begin
            tok_d = tok_q + 3'd1;
            sub_d = 4'd0;
          end
        end else begin
          sub_d = sub_q + 4'd1;
        end
      end
      S_NL: if (char_ready_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The character for the next position is rendered ahead so char_out is a flop.
  always_comb begin
    dec_d   = decode(inst_d);
    fmt_d   = dec_d.fmt;
    mlen_d  = dec_d.mlen;
    err_d   = accept ? dec_d.illegal : err_q;
    valid_d = (state_d != S_IDLE);
    last_d  = (state_d == S_NL);
    d_tok   = tok_at(dec_d.fmt, tok_d);
    char_d  = 8'h00;
    case (state_d)
      S_MNEM: begin
        case (sub_d)
          4'd0:    char_d = dec_d.mnem[39:32];
          4'd1:    char_d = dec_d.mnem[31:24];
          4'd2:    char_d = dec_d.mnem[23:16];
          4'd3:    char_d = dec_d.mnem[15:8];
          4'd4:    char_d = dec_d.mnem[7:0];
          default: char_d = 8'h20;
        endcase
      end
      S_OPS: char_d = tok_char(d_tok, sub_d,
                               sel_reg(d_tok, {inst_d[24:20], inst_d[19:15], inst_d[11:7]}),
                               dec_d.imm);
      S_NL:    char_d = 8'h0A;
      default: char_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      tok_q   <= 3'd0;
      sub_q   <= 4'd0;
      inst_q  <= 32'd0;
      fmt_q   <= F_ERR;
      mlen_q  <= 3'd3;
      err_q   <= 1'b0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tok_q   <= tok_d;
      sub_q   <= sub_d;
      inst_q  <= inst_d;
      fmt_q   <= fmt_d;
      mlen_q  <= mlen_d;
      err_q   <= err_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign inst_ready_out = (state_q == S_IDLE);
  assign char_out       = char_q;
  assign char_valid_out = valid_q;
  assign char_last_out  = last_q;
  assign error_out      = err_q;

endmodule

// File: tb/tb_riscv_disassembler.sv
// Bench for riscv_disassembler: directed lines plus random words compared
// against a string-level reference disassembler.
module tb_riscv_disassembler;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] inst_in;
  logic        inst_valid_in;
  logic        inst_ready_out;
  logic [7:0]  char_out;
  logic        char_valid_out;
  logic        char_ready_in;
  logic        char_last_out;
  logic        error_out;

  int n_vec = 0;
  int n_err = 0;

  riscv_disassembler dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .inst_in        (inst_in),
    .inst_valid_in  (inst_valid_in),
    .inst_ready_out (inst_ready_out),
    .char_out       (char_out),
    .char_valid_out (char_valid_out),
    .char_ready_in  (char_ready_in),
    .char_last_out  (char_last_out),
    .error_out      (error_out)
  );

  always #5 clk_in = ~clk_in;

  string r_mn [8] = '{"add", "sll", "slt", "sltu", "xor", "srl", "or", "and"};
  string i_mn [8] = '{"addi", "slli", "slti", "sltiu", "xori", "srli", "ori", "andi"};
  string l_mn [8] = '{"lb", "lh", "lw", "", "lbu", "lhu", "", ""};
  string s_mn [8] = '{"sb", "sh", "sw", "", "", "", "", ""};
  string b_mn [8] = '{"beq", "bne", "", "", "blt", "bge", "bltu", "bgeu"};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic string hex_s(input logic [31:0] v);
    string s;
    s = $sformatf("%08h", v);
    s = s.toupper();
    return {"0x", s};
  endfunction

  function automatic void ref_text(input logic [31:0] w, output string txt, output bit bad);
    logic [2:0] f3;
    logic [6:0] f7;
    string rd, rs1, rs2, mn, ops;
    int imm_i, imm_x;
    f3 = w[14:12];
    f7 = w[31:25];
    rd  = $sformatf("x%0d", w[11:7]);
    rs1 = $sformatf("x%0d", w[19:15]);
    rs2 = $sformatf("x%0d", w[24:20]);
    imm_i = $signed(w[31:20]);
    bad = 0;
    mn = "";
    ops = "";
    case (w[6:0])
      7'h33: begin
        mn = r_mn[f3];
        if (f7 == 7'h20 && f3 == 3'd0) mn = "sub";
        else if (f7 == 7'h20 && f3 == 3'd5) mn = "sra";
        else if (f7 != 7'h00) bad = 1;
        ops = {rd, ",", rs1, ",", rs2};
      end
      7'h13: begin
        mn = i_mn[f3];
        ops = {rd, ",", rs1, ",", hex_s(imm_i)};
        if (f3 == 3'd1 || f3 == 3'd5) begin
          ops = {rd, ",", rs1, ",", hex_s(32'(w[24:20]))};
          if (f3 == 3'd5 && f7 == 7'h20) mn = "srai";
          else if (f7 != 7'h00) bad = 1;
        end
      end
      7'h03: begin
        mn = l_mn[f3];
        bad = (mn == "");
        ops = {rd, ",", hex_s(imm_i), "(", rs1, ")"};
      end
      7'h23: begin
        mn = s_mn[f3];
        bad = (mn == "");
        imm_x = $signed({w[31:25], w[11:7]});
        ops = {rs2, ",", hex_s(imm_x), "(", rs1, ")"};
      end
      7'h63: begin
        mn = b_mn[f3];
        bad = (mn == "");
        imm_x = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
        ops = {rs1, ",", rs2, ",", hex_s(imm_x)};
      end
      7'h6F: begin
        mn = "jal";
        imm_x = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
        ops = {rd, ",", hex_s(imm_x)};
      end
      7'h67: begin
        mn = "jalr";
        bad = (f3 != 3'd0);
        ops = {rd, ",", hex_s(imm_i), "(", rs1, ")"};
      end
      7'h37: begin
        mn = "lui";
        ops = {rd, ",", hex_s(w & 32'hFFFFF000)};
      end
      7'h17: begin
        mn = "auipc";
        ops = {rd, ",", hex_s(w & 32'hFFFFF000)};
      end
      default: bad = 1;
    endcase
    if (bad) txt = {"??? ", hex_s(w), "\n"};
    else txt = {mn, " ", ops, "\n"};
  endfunction

  // mode 0: ready always 1; mode 1: random backpressure and busy-time offers;
  // mode 2: five stall cycles on character index 7
  task automatic run_inst(input logic [31:0] w, input string txt, input bit bad, input int mode);
    int idx, cyc, stalls;
    bit r;
    @(negedge clk_in);
    check_val("ready_idle", inst_ready_out, 1);
    inst_in = w;
    inst_valid_in = 1'b1;
    @(negedge clk_in);
    inst_valid_in = 1'b0;
    inst_in = $urandom;
    check_val("err_first", error_out, bad);
    idx = 0;
    cyc = 0;
    stalls = 0;
    while (idx < txt.len() && cyc < 400) begin
      check_val("ready_busy", inst_ready_out, 0);
      check_val("valid", char_valid_out, 1);
      check_val($sformatf("char[%0d]", idx), char_out, txt[idx]);
      check_val("last", char_last_out, idx == txt.len() - 1);
      r = 1'b1;
      if (mode == 1) begin
        r = ($urandom_range(0, 3) != 0);
        inst_valid_in = 1'($urandom_range(0, 1));
        inst_in = $urandom;
      end
      if (mode == 2 && idx == 7 && stalls < 5) begin
        r = 1'b0;
        stalls++;
      end
      char_ready_in = r;
      @(negedge clk_in);
      if (r) idx++;
      cyc++;
    end
    inst_valid_in = 1'b0;
    char_ready_in = 1'b1;
    if (idx < txt.len()) check_val("timeout", 0, 1);
    check_val("valid_after", char_valid_out, 0);
    check_val("ready_after", inst_ready_out, 1);
    check_val("err_hold", error_out, bad);
    $display("txn %08h mode=%0d err=%0d text=\"%s\"", w, mode, bad, txt.substr(0, txt.len() - 2));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string txt;
    bit bad;
    logic [31:0] w;
    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    rst_in = 1'b1;
    inst_in = 32'd0;
    inst_valid_in = 1'b0;
    char_ready_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check_val("rst_ready", inst_ready_out, 1);
    check_val("rst_valid", char_valid_out, 0);
    check_val("rst_char", char_out, 8'h00);
    check_val("rst_last", char_last_out, 0);
    check_val("rst_err", error_out, 0);
    rst_in = 1'b0;

    run_inst(32'h003100B3, "add x1,x2,x3\n", 0, 0);
    run_inst(32'hFFF00293, "addi x5,x0,0xFFFFFFFF\n", 0, 0);
    run_inst(32'h01012503, "lw x10,0x00000010(x2)\n", 0, 0);
    run_inst(32'hFE208CE3, "beq x1,x2,0xFFFFFFF8\n", 0, 0);
    run_inst(32'h123452B7, "lui x5,0x12345000\n", 0, 0);
    run_inst(32'h00000000, "??? 0x00000000\n", 1, 0);
    run_inst(32'h003100B3, "add x1,x2,x3\n", 0, 0);
    run_inst(32'h003100B3, "add x1,x2,x3\n", 0, 2);
    run_inst(32'h41F1DFB3, "sra x31,x3,x31\n", 0, 1);
    run_inst(32'h4051D793, "srai x15,x3,0x00000005\n", 0, 0);
    run_inst(32'h0051E793, "ori x15,x3,0x00000005\n", 0, 0);

    // abort mid-line with reset, then a fresh line from its first character
    @(negedge clk_in);
    inst_in = 32'h003100B3;
    inst_valid_in = 1'b1;
    @(negedge clk_in);
    inst_valid_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    check_val("pre_rst_char", char_out, "d");
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check_val("post_rst_valid", char_valid_out, 0);
    check_val("post_rst_ready", inst_ready_out, 1);
    check_val("post_rst_last", char_last_out, 0);
    run_inst(32'hFFF00293, "addi x5,x0,0xFFFFFFFF\n", 0, 0);

    for (int i = 0; i < 200; i++) begin
      w = $urandom;
      if ($urandom_range(0, 9) != 0) begin
        w[6:0] = ops[$urandom_range(0, 8)];
        if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
          w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      end
      ref_text(w, txt, bad);
      run_inst(w, txt, bad, i % 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
